// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// No logic; widths, default ROM window and the FSM state encoding.
// Imported by fetch_sequencer.
package fetch_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] ROM_BASE_DEF = 16'h8000;
    localparam logic [ADDR_W-1:0] ROM_LAST_DEF = 16'h8FFF;
    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Inclusive unsigned window test used for the fetch-fault decision.
    function automatic logic addr_in_window(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] lo,
                                            input logic [ADDR_W-1:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Purpose: program-ROM fetch controller; owns the PC, drives ROM address/OE,
//          registers each fetched word and offers it to decode (valid/ready).
// Latency: word captured at the edge ending its rom_oe cycle; 1 instr/cycle.
// Backpressure: instr_valid & !instr_ready stalls; PC, instr, instr_pc held, rom_oe low.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   run                fetch enable
//   rom_addr/rom_oe    ROM address (PC register) and output enable (= fire)
//   rom_data           combinational ROM read data
//   instr/instr_pc     captured instruction and its address
//   instr_valid/ready  handshake towards decode
//   redirect/_pc       load new PC, flushes held instruction
//   fault              sticky out-of-range fetch fault
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ROM_BASE = ROM_BASE_DEF,
    parameter logic [ADDR_W-1:0] ROM_LAST = ROM_LAST_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_oe,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fault
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              fault_q, fault_d;

    logic in_range;
    logic slot_free;
    logic fire;

    assign in_range  = addr_in_window(pc_q, ROM_BASE, ROM_LAST);
    // The output register can take a new word if empty or being drained now.
    assign slot_free = !instr_valid_q || instr_ready;
    assign fire      = (state_q == ST_FETCH) && run && slot_free && in_range && !redirect;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;

        if (redirect) begin
            // Target is not range-checked here; a bad target faults on the
            // next fetch attempt instead.
            pc_d          = redirect_pc;
            instr_valid_d = 1'b0;
            fault_d       = 1'b0;
            state_d       = run ? ST_FETCH : ST_IDLE;
        end else begin
            if (instr_valid_q && instr_ready) begin
                instr_valid_d = 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!run) begin
                        state_d = ST_IDLE;
                    end else if (slot_free && !in_range) begin
                        // PC held so the offending address stays visible.
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (fire) begin
                instr_d       = rom_data;
                instr_pc_d    = pc_q;
                instr_valid_d = 1'b1;
                pc_d          = pc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign rom_addr    = pc_q;
    assign rom_oe      = fire;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: directed stimulus pushes the
// instructions decode is expected to accept; a negedge monitor pops and
// compares each accepted transfer.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] rom_addr;
    logic        rom_oe;
    logic [31:0] rom_data;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        fault;

    int n_vec = 0;
    int n_err = 0;

    logic [47:0] exp_q[$];

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .rom_addr    (rom_addr),
        .rom_oe      (rom_oe),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fault       (fault)
    );

    // ROM model
    assign rom_data = {16'hA5A5, rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [15:0] pc);
        exp_q.push_back({i, pc});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rom_addr"},    {16'h0, rom_addr}, 32'h8000);
        chk({tag, " rom_oe"},      {31'h0, rom_oe}, 32'h0);
        chk({tag, " instr"},       instr, 32'h0);
        chk({tag, " instr_pc"},    {16'h0, instr_pc}, 32'h0);
        chk({tag, " instr_valid"}, {31'h0, instr_valid}, 32'h0);
        chk({tag, " fault"},       {31'h0, fault}, 32'h0);
    endtask

    // Monitor: every accepted transfer must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, expected nothing", instr_pc, instr);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                chk("sb_instr", instr, e[47:16]);
                chk("sb_instr_pc", {16'h0, instr_pc}, {16'h0, e[15:0]});
            end
        end
    end

    initial begin
        bit found;
        rst = 1'b1; run = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        repeat (2) sample;
        chk_reset_vals("reset");
        tick;
        rst = 1'b0;

        // Streaming from reset
        push(32'hA5A58000, 16'h8000);
        push(32'hA5A58001, 16'h8001);
        push(32'hA5A58002, 16'h8002);
        push(32'hA5A58003, 16'h8003);
        run = 1'b1; instr_ready = 1'b1;
        sample;
        chk("idle_no_oe", {31'h0, rom_oe}, 32'h0);
        tick; sample;
        chk("first_oe", {31'h0, rom_oe}, 32'h1);
        chk("first_addr", {16'h0, rom_addr}, 32'h8000);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick;
            if (instr_valid && instr_pc == 16'h8003) found = 1'b1;
        end
        instr_ready = 1'b0;
        chk("reach_8003", {31'h0, found}, 32'h1);

        // Stall three cycles
        for (int i = 0; i < 3; i++) begin
            sample;
            chk("stall_instr", instr, 32'hA5A58003);
            chk("stall_pc", {16'h0, instr_pc}, 32'h8003);
            chk("stall_oe", {31'h0, rom_oe}, 32'h0);
            chk("stall_addr", {16'h0, rom_addr}, 32'h8004);
            tick;
        end
        instr_ready = 1'b1;
        push(32'hA5A58004, 16'h8004);
        sample;
        chk("release_oe", {31'h0, rom_oe}, 32'h1);
        tick; sample;
        chk("release_pc", {16'h0, instr_pc}, 32'h8004);

        // Redirect while valid (8005 held, flushed)
        tick;
        instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h8FFE;
        sample;
        chk("redir_no_oe", {31'h0, rom_oe}, 32'h0);
        chk("redir_held_valid", {31'h0, instr_valid}, 32'h1);
        tick;
        redirect = 1'b0; instr_ready = 1'b1;
        push(32'hA5A58FFE, 16'h8FFE);
        push(32'hA5A58FFF, 16'h8FFF);
        sample;
        chk("redir_flush", {31'h0, instr_valid}, 32'h0);
        chk("redir_addr", {16'h0, rom_addr}, 32'h8FFE);
        chk("redir_oe", {31'h0, rom_oe}, 32'h1);
        tick; tick; sample;
        chk("wrap_no_oe", {31'h0, rom_oe}, 32'h0);
        chk("wrap_addr", {16'h0, rom_addr}, 32'h9000);
        chk("wrap_fault_pre", {31'h0, fault}, 32'h0);
        tick; sample;
        chk("wrap_fault", {31'h0, fault}, 32'h1);
        chk("wrap_valid", {31'h0, instr_valid}, 32'h0);
        chk("wrap_oe", {31'h0, rom_oe}, 32'h0);
        chk("wrap_addr_hold", {16'h0, rom_addr}, 32'h9000);

        // Redirect to out-of-range target, then recover
        tick;
        redirect = 1'b1; redirect_pc = 16'h1234;
        sample;
        tick;
        redirect = 1'b0;
        sample;
        chk("bad_tgt_fault_clr", {31'h0, fault}, 32'h0);
        chk("bad_tgt_addr", {16'h0, rom_addr}, 32'h1234);
        chk("bad_tgt_oe", {31'h0, rom_oe}, 32'h0);
        tick; sample;
        chk("bad_tgt_fault", {31'h0, fault}, 32'h1);
        tick;
        redirect = 1'b1; redirect_pc = 16'h8000;
        push(32'hA5A58000, 16'h8000);
        push(32'hA5A58001, 16'h8001);
        sample;
        chk("fault_sticky", {31'h0, fault}, 32'h1);
        tick;
        redirect = 1'b0;
        sample;
        chk("recover_fault", {31'h0, fault}, 32'h0);
        chk("recover_oe", {31'h0, rom_oe}, 32'h1);
        chk("recover_addr", {16'h0, rom_addr}, 32'h8000);

        // Drop run with an instruction held
        tick; tick;
        instr_ready = 1'b0; run = 1'b0;
        sample;
        chk("runoff_oe", {31'h0, rom_oe}, 32'h0);
        chk("runoff_valid", {31'h0, instr_valid}, 32'h1);
        tick; tick; sample;
        chk("runoff_hold_valid", {31'h0, instr_valid}, 32'h1);
        chk("runoff_hold_pc", {16'h0, instr_pc}, 32'h8001);
        chk("runoff_hold_oe", {31'h0, rom_oe}, 32'h0);
        tick;
        instr_ready = 1'b1;
        sample;
        tick; sample;
        chk("runoff_drained", {31'h0, instr_valid}, 32'h0);
        chk("runoff_idle_oe", {31'h0, rom_oe}, 32'h0);
        tick;
        run = 1'b1;
        sample;
        chk("idle_again_oe", {31'h0, rom_oe}, 32'h0);
        chk("idle_again_addr", {16'h0, rom_addr}, 32'h8002);
        push(32'hA5A58002, 16'h8002);
        push(32'hA5A58003, 16'h8003);
        tick; sample;
        chk("resume_oe", {31'h0, rom_oe}, 32'h1);

        // Asynchronous reset between edges
        tick; tick; tick;
        instr_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        rst = 1'b0;
        sample;
        chk("post_rst_idle_oe", {31'h0, rom_oe}, 32'h0);
        tick; sample;
        chk("post_rst_oe", {31'h0, rom_oe}, 32'h1);
        chk("post_rst_addr", {16'h0, rom_addr}, 32'h8000);
        tick;
        run = 1'b0;
        repeat (2) tick;

        chk("sb_leftover", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
